// File: rtl/control_pkg.sv
// Shared encodings for the M-extension multiply/divide sequencer.
package control_pkg;

  typedef enum logic [1:0] {StIdle, StIter, StFixup, StDone} muldiv_state_e;

  localparam logic [2:0] Funct3Mul    = 3'b000;
  localparam logic [2:0] Funct3Mulh   = 3'b001;
  localparam logic [2:0] Funct3Mulhsu = 3'b010;
  localparam logic [2:0] Funct3Mulhu  = 3'b011;
  localparam logic [2:0] Funct3Div    = 3'b100;
  localparam logic [2:0] Funct3Divu   = 3'b101;
  localparam logic [2:0] Funct3Rem    = 3'b110;
  localparam logic [2:0] Funct3Remu   = 3'b111;

  localparam logic [6:0] Funct7MulDiv = 7'b0000001;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring divide.
module muldiv_step #(
  parameter int unsigned XLEN = 64
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [2*XLEN-1:0] mcand_i,
  input  logic [XLEN-1:0]   mplier_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic [2*XLEN-1:0] mcand_o,
  output logic [XLEN-1:0]   mplier_o
);

  // Divide keeps {remainder, dividend/quotient} in acc; divisor sits in mcand low half.
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  assign rem_sh = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
  assign diff   = rem_sh - {1'b0, mcand_i[XLEN-1:0]};

  always_comb begin
    acc_o    = acc_i;
    mcand_o  = mcand_i;
    mplier_o = mplier_i;
    if (is_div_i) begin
      acc_o = {(diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0]), acc_i[XLEN-2:0], ~diff[XLEN]};
    end else begin
      if (mplier_i[0]) begin
        acc_o = acc_i + mcand_i;
      end
      mcand_o  = mcand_i << 1;
      mplier_o = mplier_i >> 1;
    end
  end

endmodule

// File: rtl/muldiv_sched.sv
// Iterative M-extension multiply/divide sequencer with pipeline stall and done pulse.
// MULDIV_FAST_MUL_EN: single-cycle multiplies at accept; divides stay iterative.
module muldiv_sched
  import control_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic            is_word_op_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CntW      = $clog2(XLEN);
  localparam int unsigned WordShift = XLEN - 32;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{WordShift{v[31]}}, v};
  endfunction

  // Magnitude of the operative-width operand, zero-extended to XLEN.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic word,
                                          input logic neg);
    logic [XLEN-1:0] t;
    t = neg ? (~v + 1'b1) : v;
    if (word) t = {{WordShift{1'b0}}, t[31:0]};
    return t;
  endfunction

  muldiv_state_e     state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              word_q, word_d, neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [2*XLEN-1:0] step_acc, step_mcand;
  logic [XLEN-1:0]   step_mplier;

  logic            sa, sb, sgn_a, sgn_b, is_div, is_rem, word_illegal;
  logic            b_zero, a_min, b_m1, ovf, special, fast_hit, accept;
  logic [XLEN-1:0] a_mag, b_mag, special_res, fast_res, fix_res, dv;
  logic [2*XLEN-1:0] prod;

  assign sa     = is_word_op_i ? op_a_i[31] : op_a_i[XLEN-1];
  assign sb     = is_word_op_i ? op_b_i[31] : op_b_i[XLEN-1];
  assign sgn_a  = funct3_i inside {Funct3Mulh, Funct3Mulhsu, Funct3Div, Funct3Rem};
  assign sgn_b  = funct3_i inside {Funct3Mulh, Funct3Div, Funct3Rem};
  assign a_mag  = mag(op_a_i, is_word_op_i, sgn_a & sa);
  assign b_mag  = mag(op_b_i, is_word_op_i, sgn_b & sb);
  assign is_div = funct3_i[2];
  assign is_rem = funct3_i[1];

  assign word_illegal = is_word_op_i & ~funct3_i[2] & (funct3_i[1:0] != 2'b00);
  assign b_zero = is_word_op_i ? (op_b_i[31:0] == 32'd0) : (op_b_i == '0);
  assign a_min  = is_word_op_i ? (op_a_i[31:0] == 32'h8000_0000)
                               : (op_a_i == {1'b1, {(XLEN-1){1'b0}}});
  assign b_m1   = is_word_op_i ? (op_b_i[31:0] == 32'hFFFF_FFFF) : (op_b_i == '1);
  assign ovf    = is_div & ~funct3_i[0] & a_min & b_m1;
  assign accept = (state_q == StIdle) & start_i & ~flush_i;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fa, fb, fprod;
  assign fa    = sgn_a ? {{XLEN{op_a_i[XLEN-1]}}, op_a_i} : {{XLEN{1'b0}}, op_a_i};
  assign fb    = sgn_b ? {{XLEN{op_b_i[XLEN-1]}}, op_b_i} : {{XLEN{1'b0}}, op_b_i};
  assign fprod = fa * fb;
  assign fast_hit = ~is_div;
  assign fast_res = (funct3_i == Funct3Mul)
                  ? (is_word_op_i ? sext32(fprod[31:0]) : fprod[XLEN-1:0])
                  : fprod[2*XLEN-1:XLEN];
`else
  assign fast_hit = 1'b0;
  assign fast_res = '0;
`endif

  always_comb begin
    special     = 1'b1;
    special_res = '0;
    if (word_illegal) begin
      special_res = '0;
    end else if (is_div && b_zero) begin
      special_res = is_rem ? (is_word_op_i ? sext32(op_a_i[31:0]) : op_a_i) : '1;
    end else if (ovf) begin
      special_res = is_rem ? '0
                  : (is_word_op_i ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}});
    end else if (fast_hit) begin
      special_res = fast_res;
    end else begin
      special = 1'b0;
    end
  end

  always_comb begin
    unique case (funct3_i)
      Funct3Mulh, Funct3Div:   neg_d = sa ^ sb;
      Funct3Mulhsu, Funct3Rem: neg_d = sa;
      default:                 neg_d = 1'b0;
    endcase
  end

  // Sign fix-up and half/quotient/remainder selection.
  always_comb begin
    prod = neg_q ? (~acc_q + 1'b1) : acc_q;
    dv   = funct3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    if (neg_q) dv = ~dv + 1'b1;
    if (funct3_q[2]) begin
      fix_res = word_q ? sext32(dv[31:0]) : dv;
    end else if (funct3_q == Funct3Mul) begin
      fix_res = word_q ? sext32(prod[31:0]) : prod[XLEN-1:0];
    end else begin
      fix_res = prod[2*XLEN-1:XLEN];
    end
  end

  muldiv_step #(
    .XLEN(XLEN)
  ) u_step (
    .is_div_i (funct3_q[2]),
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .acc_o    (step_acc),
    .mcand_o  (step_mcand),
    .mplier_o (step_mplier)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    funct3_d = funct3_q;
    word_d   = word_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          funct3_d = funct3_i;
          word_d   = is_word_op_i;
          mcand_d  = {{XLEN{1'b0}}, (is_div ? b_mag : a_mag)};
          mplier_d = is_div ? '0 : b_mag;
          acc_d    = is_div ? {{XLEN{1'b0}}, (is_word_op_i ? (a_mag << WordShift) : a_mag)}
                            : '0;
          if (special) begin
            result_d = special_res;
            state_d  = StDone;
          end else begin
            cnt_d   = is_word_op_i ? CntW'(31) : CntW'(XLEN - 1);
            state_d = StIter;
          end
        end
      end
      StIter: begin
        acc_d    = step_acc;
        mcand_d  = step_mcand;
        mplier_d = step_mplier;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = StFixup;
      end
      StFixup: begin
        result_d = fix_res;
        state_d  = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
    if (flush_i) begin
      state_d  = StIdle;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      funct3_q <= '0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      funct3_q <= funct3_d;
      word_q   <= word_d;
      neg_q    <= accept ? neg_d : neg_q;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q != StIdle);
  assign done_o   = (state_q == StDone) & ~flush_i;
  assign stall_o  = accept | (state_q == StIter) | (state_q == StFixup);
  assign result_o = result_q;

endmodule
